// File: rtl/timer_tc_if.sv
// rtl/timer_tc_if.sv - word-access bus between the system bridge and one timer window
interface timer_tc_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_tc.sv
// rtl/timer_tc.sv - memory-mapped countdown timer with one-shot/auto-reload modes and CP0 IRQ
module timer_tc (
    input  logic        clk,
    input  logic        reset,
    timer_tc_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic [1:0]  reg_sel;
    logic        wr_ctrl, wr_preset;
    logic        ctrl_en, auto_reload;
    logic        unused_addr_bits;

    assign reg_sel          = bus.Addr[3:2];
    assign unused_addr_bits = ^{bus.Addr[31:4], bus.Addr[1:0]};
    assign wr_ctrl          = bus.WE && (reg_sel == 2'b00);
    assign wr_preset        = bus.WE && (reg_sel == 2'b01);
    assign ctrl_en          = ctrl_q[0];
    assign auto_reload      = (ctrl_q[2:1] == 2'b01);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        if (wr_ctrl || wr_preset) begin
            // Software access restarts the sequence; COUNT is held where it is.
            state_d    = S_IDLE;
            irq_flag_d = 1'b0;
            if (wr_ctrl) begin
                ctrl_d = bus.Din[3:0];
            end else begin
                preset_d = bus.Din;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_en) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_en) begin
                        state_d = S_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        // PRESET of 0 lands here too, so it behaves like 1.
                        count_d    = 32'd0;
                        irq_flag_d = 1'b1;
                        state_d    = S_INT;
                    end
                end
                S_INT: begin
                    state_d = S_IDLE;
                    if (auto_reload) begin
                        irq_flag_d = 1'b0;
                    end else begin
                        ctrl_d[0] = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        bus.Dout = 32'd0;
        case (reg_sel)
            2'b00:   bus.Dout = {28'd0, ctrl_q};
            2'b01:   bus.Dout = preset_q;
            2'b10:   bus.Dout = count_q;
            default: bus.Dout = 32'd0;
        endcase
    end

    assign bus.IRQ = ctrl_q[3] & irq_flag_q;
endmodule

// File: tb/tb_timer_tc.sv
// tb/tb_timer_tc.sv - scoreboard-driven self-checking bench for timer_tc
module tb_timer_tc;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    logic [31:0] exp_count[$];
    logic        exp_irq[$];

    timer_tc_if bus ();

    timer_tc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Addr = a;
        bus.Din  = d;
        bus.WE   = 1'b1;
        tick();
        bus.WE   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.Addr = a;
        #1;
        d = bus.Dout;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset   = 1'b1;
        bus.WE  = 1'b0;
        bus.Addr = 32'h0;
        bus.Din = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(32'h7f00 + i * 4, d);
            checks++;
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL reset_dout off=%0d got=%h exp=0", i * 4, d);
            end
        end
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", bus.IRQ);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] d, ec;
        logic        ei;
        wr(32'h7f04, 32'd3);
        wr(32'h7f00, 32'h9);
        exp_count.push_back(32'd0); exp_irq.push_back(1'b0);
        exp_count.push_back(32'd3); exp_irq.push_back(1'b0);
        exp_count.push_back(32'd2); exp_irq.push_back(1'b0);
        exp_count.push_back(32'd1); exp_irq.push_back(1'b0);
        exp_count.push_back(32'd0); exp_irq.push_back(1'b1);
        for (int e = 1; e <= 5; e++) begin
            tick();
            rd(32'h7f08, d);
            ec = exp_count.pop_front();
            ei = exp_irq.pop_front();
            checks++;
            if (d !== ec) begin
                failures++;
                $display("FAIL oneshot_count edge=%0d got=%0d exp=%0d", e, d, ec);
            end
            checks++;
            if (bus.IRQ !== ei) begin
                failures++;
                $display("FAIL oneshot_irq edge=%0d got=%b exp=%b", e, bus.IRQ, ei);
            end
        end
        tick();
        rd(32'h7f00, d);
        checks++;
        if (d !== 32'h8) begin
            failures++;
            $display("FAIL oneshot_ctrl_after got=%h exp=8", d);
        end
        checks++;
        if (bus.IRQ !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_irq_held got=%b exp=1", bus.IRQ);
        end
        wr(32'h7f00, 32'h8);
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_irq_clear got=%b exp=0", bus.IRQ);
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        logic        ei;
        wr(32'h7f04, 32'd2);
        wr(32'h7f00, 32'hB);
        for (int e = 1; e <= 15; e++) begin
            exp_irq.push_back((e >= 4) && ((e - 4) % 5 == 0));
        end
        for (int e = 1; e <= 15; e++) begin
            tick();
            ei = exp_irq.pop_front();
            checks++;
            if (bus.IRQ !== ei) begin
                failures++;
                $display("FAIL reload_irq edge=%0d got=%b exp=%b", e, bus.IRQ, ei);
            end
        end
        rd(32'h7f00, d);
        checks++;
        if (d !== 32'hB) begin
            failures++;
            $display("FAIL reload_ctrl got=%h exp=b", d);
        end
        wr(32'h7f00, 32'h0);
    endtask

    task automatic test_preset_zero();
        logic ei;
        wr(32'h7f04, 32'd0);
        wr(32'h7f00, 32'h9);
        exp_irq.push_back(1'b0);
        exp_irq.push_back(1'b0);
        exp_irq.push_back(1'b1);
        for (int e = 1; e <= 3; e++) begin
            tick();
            ei = exp_irq.pop_front();
            checks++;
            if (bus.IRQ !== ei) begin
                failures++;
                $display("FAIL preset0_irq edge=%0d got=%b exp=%b", e, bus.IRQ, ei);
            end
        end
        wr(32'h7f00, 32'h0);
    endtask

    task automatic test_masked();
        logic [31:0] d;
        wr(32'h7f04, 32'd1);
        wr(32'h7f00, 32'h1);
        for (int e = 1; e <= 5; e++) begin
            tick();
            checks++;
            if (bus.IRQ !== 1'b0) begin
                failures++;
                $display("FAIL masked_irq edge=%0d got=%b exp=0", e, bus.IRQ);
            end
        end
        rd(32'h7f08, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL masked_count got=%0d exp=0", d);
        end
        rd(32'h7f00, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL masked_ctrl got=%h exp=0", d);
        end
        wr(32'h7f00, 32'h9);
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL masked_unmask_irq got=%b exp=0", bus.IRQ);
        end
        wr(32'h7f00, 32'h0);
    endtask

    task automatic test_ignored_writes();
        logic [31:0] d, ec;
        logic        ei;
        wr(32'h7f04, 32'd5);
        wr(32'h7f00, 32'h9);
        for (int e = 1; e <= 7; e++) begin
            exp_count.push_back((e < 2) ? 32'd0 : 32'(7 - e));
            exp_irq.push_back(e == 7);
        end
        for (int e = 1; e <= 7; e++) begin
            if (e == 3) begin
                bus.Addr = 32'h7f08; bus.Din = 32'h1234; bus.WE = 1'b1;
            end else if (e == 4) begin
                bus.Addr = 32'h7f0c; bus.Din = 32'hFFFF; bus.WE = 1'b1;
            end
            tick();
            bus.WE = 1'b0;
            rd(32'h7f08, d);
            ec = exp_count.pop_front();
            ei = exp_irq.pop_front();
            checks++;
            if (d !== ec) begin
                failures++;
                $display("FAIL ignored_count edge=%0d got=%0d exp=%0d", e, d, ec);
            end
            checks++;
            if (bus.IRQ !== ei) begin
                failures++;
                $display("FAIL ignored_irq edge=%0d got=%b exp=%b", e, bus.IRQ, ei);
            end
        end
        rd(32'h7f0c, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_read got=%h exp=0", d);
        end
        wr(32'h7f00, 32'h0);
    endtask

    task automatic test_disable_reset();
        logic [31:0] d, ec;
        wr(32'h7f04, 32'd10);
        wr(32'h7f00, 32'h9);
        exp_count.push_back(32'd0);
        exp_count.push_back(32'd10);
        exp_count.push_back(32'd9);
        exp_count.push_back(32'd8);
        for (int e = 1; e <= 4; e++) begin
            tick();
            rd(32'h7f08, d);
            ec = exp_count.pop_front();
            checks++;
            if (d !== ec) begin
                failures++;
                $display("FAIL disable_pre_count edge=%0d got=%0d exp=%0d", e, d, ec);
            end
        end
        wr(32'h7f00, 32'h0);
        for (int i = 0; i < 4; i++) exp_count.push_back(32'd8);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            rd(32'h7f08, d);
            ec = exp_count.pop_front();
            checks++;
            if (d !== ec) begin
                failures++;
                $display("FAIL disable_frozen_count cyc=%0d got=%0d exp=%0d", i, d, ec);
            end
            checks++;
            if (bus.IRQ !== 1'b0) begin
                failures++;
                $display("FAIL disable_irq cyc=%0d got=%b exp=0", i, bus.IRQ);
            end
        end
        wr(32'h7f00, 32'h9);
        tick(); tick(); tick();
        rd(32'h7f08, d);
        checks++;
        if (d !== 32'd9) begin
            failures++;
            $display("FAIL restart_count got=%0d exp=9", d);
        end
        bus.Addr = 32'h7f04; bus.Din = 32'd5; bus.WE = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(32'h7f00 + i * 4, d);
            checks++;
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL midreset_dout off=%0d got=%h exp=0", i * 4, d);
            end
        end
        checks++;
        if (bus.IRQ !== 1'b0) begin
            failures++;
            $display("FAIL midreset_irq got=%b exp=0", bus.IRQ);
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.WE   = 1'b0;
        bus.Addr = 32'h0;
        bus.Din  = 32'h0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_preset_zero();
        test_masked();
        test_ignored_writes();
        test_disable_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
